// File: rtl/decode_issue.sv
// LC-3 decode / operand-issue stage: ADD/AND/NOT decode, 8x16 register file,
// busy scoreboard with writeback release. Optional macro DECODE_FWD_EN enables
// same-cycle writeback forwarding into operand reads and hazard checks.
module decode_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_inst,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_opcode,
  output logic [15:0] out_a,
  output logic [15:0] out_b,
  output logic [2:0]  out_dr,
  input  logic        wb_en,
  input  logic [2:0]  wb_dr,
  input  logic [15:0] wb_data,
  output logic        illegal,
  output logic [15:0] stall_cnt
);

  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_NOT = 4'b1001;

  logic [15:0] r_rf [0:7];
  logic [7:0]  r_busy;
  logic        r_out_valid;
  logic [3:0]  r_opcode;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [2:0]  r_dr;
  logic        r_illegal;
  logic [15:0] r_stall_cnt;

  logic [3:0]  w_op;
  logic [2:0]  w_dr;
  logic [2:0]  w_sr1;
  logic [2:0]  w_sr2;
  logic        w_imm;
  logic [15:0] w_sext;
  logic        w_is_arith;
  logic        w_legal;
  logic        w_use_sr2;
  logic [7:0]  w_wb_mask;
  logic [7:0]  w_busy_src;
  logic [7:0]  w_busy_dst;
  logic [15:0] w_rd_a;
  logic [15:0] w_rd_b;
  logic [15:0] w_b;
  logic        w_hazard;
  logic        w_slot;
  logic        w_accept;
  logic        w_issue;
  logic        w_consume_ill;
  logic [7:0]  w_busy_next;

  assign w_op       = in_inst[15:12];
  assign w_dr       = in_inst[11:9];
  assign w_sr1      = in_inst[8:6];
  assign w_imm      = in_inst[5];
  assign w_sr2      = in_inst[2:0];
  assign w_sext     = {{11{in_inst[4]}}, in_inst[4:0]};
  assign w_is_arith = (w_op == OP_ADD) | (w_op == OP_AND);
  assign w_legal    = w_is_arith | (w_op == OP_NOT);
  assign w_use_sr2  = w_is_arith & ~w_imm;
  assign w_wb_mask  = wb_en ? (8'b0000_0001 << wb_dr) : 8'b0000_0000;

`ifdef DECODE_FWD_EN
  // A register being written back this cycle is free and its new value is visible.
  assign w_busy_src = r_busy & ~w_wb_mask;
  assign w_busy_dst = r_busy & ~w_wb_mask;
  assign w_rd_a     = (wb_en && (wb_dr == w_sr1)) ? wb_data : r_rf[w_sr1];
  assign w_rd_b     = (wb_en && (wb_dr == w_sr2)) ? wb_data : r_rf[w_sr2];
`else
  // Without forwarding the read sees stale data, so a source under writeback must wait.
  assign w_busy_src = r_busy | w_wb_mask;
  assign w_busy_dst = r_busy;
  assign w_rd_a     = r_rf[w_sr1];
  assign w_rd_b     = r_rf[w_sr2];
`endif

  assign w_hazard = w_legal & (w_busy_src[w_sr1] |
                               (w_use_sr2 & w_busy_src[w_sr2]) |
                               w_busy_dst[w_dr]);
  assign w_slot   = ~r_out_valid | out_ready;

  // Handshake ready: illegal words skip the hazard check.
  always_comb begin
    in_ready = 1'b0;
    if (w_legal) begin
      in_ready = ~w_hazard & w_slot;
    end else begin
      in_ready = w_slot;
    end
  end

  assign w_accept      = in_valid & in_ready;
  assign w_issue       = w_accept & w_legal;
  assign w_consume_ill = w_accept & ~w_legal;

  // Operand B selection by opcode.
  always_comb begin
    w_b = 16'h0000;
    case (w_op)
      OP_ADD, OP_AND: begin
        if (w_imm) begin
          w_b = w_sext;
        end else begin
          w_b = w_rd_b;
        end
      end
      OP_NOT:  w_b = 16'h0000;
      default: w_b = 16'h0000;
    endcase
  end

  // Scoreboard update: writeback clears, issue sets, set wins on the same index.
  always_comb begin
    w_busy_next = r_busy;
    if (wb_en) begin
      w_busy_next = w_busy_next & ~w_wb_mask;
    end else begin
      w_busy_next = w_busy_next;
    end
    if (w_issue) begin
      w_busy_next = w_busy_next | (8'b0000_0001 << w_dr);
    end else begin
      w_busy_next = w_busy_next;
    end
  end

  // Register file and scoreboard state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_rf[i] <= 16'h0000;
      end
      r_busy <= 8'h00;
    end else begin
      if (wb_en) begin
        r_rf[wb_dr] <= wb_data;
      end
      r_busy <= w_busy_next;
    end
  end

  // Issue bundle register; holds while the ALU back-pressures.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_opcode    <= 4'h0;
      r_a         <= 16'h0000;
      r_b         <= 16'h0000;
      r_dr        <= 3'h0;
    end else if (w_issue) begin
      r_out_valid <= 1'b1;
      r_opcode    <= w_op;
      r_a         <= w_rd_a;
      r_b         <= w_b;
      r_dr        <= w_dr;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Illegal-word pulse and saturating hazard-stall counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_illegal   <= 1'b0;
      r_stall_cnt <= 16'h0000;
    end else begin
      r_illegal <= w_consume_ill;
      if (in_valid && !in_ready && w_hazard && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'h0001;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_opcode = r_opcode;
  assign out_a      = r_a;
  assign out_b      = r_b;
  assign out_dr     = r_dr;
  assign illegal    = r_illegal;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed test-plan steps then random traffic, all
// checked every cycle against a behavioural register/scoreboard model.
module tb_decode_issue;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_inst;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [15:0] out_a;
  logic [15:0] out_b;
  logic [2:0]  out_dr;
  logic        wb_en;
  logic [2:0]  wb_dr;
  logic [15:0] wb_data;
  logic        illegal;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_rf [8];
  bit          m_busy [8];
  bit          m_ov;
  logic [3:0]  m_op;
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic [2:0]  m_dr;
  bit          m_ill;
  logic [15:0] m_stall;

  decode_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_inst(in_inst),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_a(out_a), .out_b(out_b), .out_dr(out_dr),
    .wb_en(wb_en), .wb_dr(wb_dr), .wb_data(wb_data), .illegal(illegal),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_op(input logic [3:0] op);
    return (op == 4'd1) || (op == 4'd5) || (op == 4'd9);
  endfunction

  function automatic bit wb_hits(input int r);
    return wb_en && (int'(wb_dr) == r);
  endfunction

  function automatic bit src_busy(input int r);
`ifdef DECODE_FWD_EN
    return m_busy[r] && !wb_hits(r);
`else
    return m_busy[r] || wb_hits(r);
`endif
  endfunction

  function automatic bit dst_busy(input int r);
`ifdef DECODE_FWD_EN
    return m_busy[r] && !wb_hits(r);
`else
    return m_busy[r];
`endif
  endfunction

  function automatic logic [15:0] rd(input int r);
`ifdef DECODE_FWD_EN
    if (wb_hits(r)) return wb_data;
`endif
    return m_rf[r];
  endfunction

  function automatic bit m_hazard();
    int op, dr, s1, s2;
    bit regmode;
    op = int'(in_inst[15:12]);
    dr = int'(in_inst[11:9]);
    s1 = int'(in_inst[8:6]);
    s2 = int'(in_inst[2:0]);
    if (!legal_op(in_inst[15:12])) return 1'b0;
    regmode = (op != 9) && !in_inst[5];
    return src_busy(s1) || (regmode && src_busy(s2)) || dst_busy(dr);
  endfunction

  function automatic bit m_ready();
    bit slot;
    slot = !m_ov || out_ready;
    return slot && !m_hazard();
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_rf[i] = 16'h0000;
      m_busy[i] = 1'b0;
    end
    m_ov = 1'b0; m_op = 4'h0; m_a = 16'h0000; m_b = 16'h0000; m_dr = 3'h0;
    m_ill = 1'b0; m_stall = 16'h0000;
  endtask

  // Effect of one rising edge on the model, given the inputs held across it.
  task automatic model_edge();
    bit rdy, haz, leg, acc;
    int dr;
    logic [15:0] a, b;
    if (!rst_n) begin
      model_reset();
    end else begin
      rdy = m_ready();
      haz = m_hazard();
      leg = legal_op(in_inst[15:12]);
      acc = in_valid && rdy;
      dr  = int'(in_inst[11:9]);
      a   = rd(int'(in_inst[8:6]));
      if (in_inst[15:12] == 4'd9) b = 16'h0000;
      else if (in_inst[5]) b = 16'($signed(in_inst[4:0]));
      else b = rd(int'(in_inst[2:0]));
      if (in_valid && !rdy && haz && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      m_ill = acc && !leg;
      if (acc && leg) begin
        m_ov = 1'b1; m_op = in_inst[15:12]; m_a = a; m_b = b; m_dr = in_inst[11:9];
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
      if (wb_en) begin
        m_rf[wb_dr] = wb_data;
        m_busy[wb_dr] = 1'b0;
      end
      if (acc && leg) m_busy[dr] = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("in_ready", 16'(in_ready), 16'(m_ready()));
    chk("out_valid", 16'(out_valid), 16'(m_ov));
    chk("out_opcode", 16'(out_opcode), 16'(m_op));
    chk("out_a", out_a, m_a);
    chk("out_b", out_b, m_b);
    chk("out_dr", 16'(out_dr), 16'(m_dr));
    chk("illegal", 16'(illegal), 16'(m_ill));
    chk("stall_cnt", stall_cnt, m_stall);
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic drive(input bit v, input logic [15:0] inst, input bit ordy,
                       input bit we, input logic [2:0] wd, input logic [15:0] wdat);
    in_valid = v; in_inst = inst; out_ready = ordy;
    wb_en = we; wb_dr = wd; wb_data = wdat;
    tick();
  endtask

  initial begin
    logic [15:0] inst;
    logic [3:0]  op;
    rst_n = 1'b0; in_valid = 1'b0; in_inst = 16'h0000; out_ready = 1'b1;
    wb_en = 1'b0; wb_dr = 3'd0; wb_data = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    drive(0, 16'h0000, 1, 0, 3'd0, 16'h0000);
    rst_n = 1'b1;
    chk("rst_stall", stall_cnt, 16'h0000);
    chk("rst_valid", 16'(out_valid), 16'h0000);
    drive(0, 16'h0000, 1, 1, 3'd1, 16'h0005);
    chk("rst_ready", 16'(in_ready), 16'h0001);
    drive(0, 16'h0000, 1, 1, 3'd2, 16'h0003);
    // ADD R3,R1,R2
    drive(1, 16'h1642, 1, 0, 3'd0, 16'h0000);
    chk("add_valid", 16'(out_valid), 16'h0001);
    chk("add_op", 16'(out_opcode), 16'h0001);
    chk("add_a", out_a, 16'h0005);
    chk("add_b", out_b, 16'h0003);
    chk("add_dr", 16'(out_dr), 16'h0003);
    // AND R4,R1,#-2 and NOT R5,R1
    drive(1, 16'h587E, 1, 0, 3'd0, 16'h0000);
    chk("and_b", out_b, 16'hFFFE);
    drive(1, 16'h9A7F, 1, 0, 3'd0, 16'h0000);
    chk("not_a", out_a, 16'h0005);
    chk("not_b", out_b, 16'h0000);
    chk("not_dr", 16'(out_dr), 16'h0005);
    // ADD R6,R3,#1 waits on R3
    repeat (3) drive(1, 16'h1CE1, 1, 0, 3'd0, 16'h0000);
    chk("raw_stall", stall_cnt, 16'h0003);
    drive(1, 16'h1CE1, 1, 1, 3'd3, 16'h0008);
`ifndef DECODE_FWD_EN
    chk("raw_wait", 16'(out_valid), 16'h0000);
    drive(1, 16'h1CE1, 1, 0, 3'd0, 16'h0000);
`endif
    chk("raw_a", out_a, 16'h0008);
    chk("raw_dr", 16'(out_dr), 16'h0006);
    // back-pressure for 3 cycles
    repeat (3) begin
      drive(1, 16'h1E42, 0, 0, 3'd0, 16'h0000);
      chk("hold_a", out_a, 16'h0008);
    end
    drive(1, 16'h1E42, 1, 0, 3'd0, 16'h0000);
    chk("rel_dr", 16'(out_dr), 16'h0007);
    chk("rel_a", out_a, 16'h0005);
    // illegal BR word
    drive(1, 16'h0000, 1, 0, 3'd0, 16'h0000);
    chk("ill_pulse", 16'(illegal), 16'h0001);
    chk("ill_novalid", 16'(out_valid), 16'h0000);
    drive(0, 16'h0000, 1, 0, 3'd0, 16'h0000);
    chk("ill_drop", 16'(illegal), 16'h0000);
    // reset while stalled on R3
    drive(1, 16'h1642, 1, 0, 3'd0, 16'h0000);
    repeat (2) drive(1, 16'h1CE1, 1, 0, 3'd0, 16'h0000);
    rst_n = 1'b0;
    drive(1, 16'h1CE1, 1, 0, 3'd0, 16'h0000);
    rst_n = 1'b1;
    chk("mid_rst_stall", stall_cnt, 16'h0000);
    chk("mid_rst_valid", 16'(out_valid), 16'h0000);
    drive(1, 16'h1CE1, 1, 0, 3'd0, 16'h0000);
    chk("post_rst_valid", 16'(out_valid), 16'h0001);
    chk("post_rst_a", out_a, 16'h0000);
    // random traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op = 4'd1;
        3, 4, 5: op = 4'd5;
        6, 7:    op = 4'd9;
        default: op = 4'($urandom_range(0, 15));
      endcase
      inst = {op, 12'($urandom)};
      drive($urandom_range(0, 3) != 0, inst, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 16'($urandom));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
